sram_wr_arbiter: RTL and testbench
==================================

// Module: sram_wr_arbiter
// PURPOSE
//  Round-robin write arbiter and access sequencer in front of the 8-word mySRAM FIFO buffer.
//  Shares the buffer's single write port between two producers and passes one consumer's reads through.
//  Keeps a local occupancy count so the buffer never overflows, and drives the buffer's registered write/read strobes.
//  Halts all traffic if the buffer reports overflow.
// PARAMETERS
//  BITS        12  data word width, equal to the buffer's BITS
//  WORD_DEPTH  8   buffer depth in words
//  ADDR_WIDTH  3   log2(WORD_DEPTH); the occupancy counter is ADDR_WIDTH+1 bits wide
// PORTS
//  clk           in   1     single clock, rising edge
//  rst_n         in   1     synchronous active-low reset
//  req0/req1     in   1     producer write request; must hold with stable data until its grant is seen
//  data0/data1   in   BITS  producer write data
//  gnt0/gnt1     out  1     combinational grant; a transfer occurs at the edge where req&gnt=1
//  rd_req        in   1     consumer read request
//  rd_gnt        out  1     combinational read grant
//  clr_err       in   1     leaves HALT; clears err
//  mem_write     out  1     registered write strobe to the buffer
//  mem_read      out  1     registered read strobe to the buffer
//  mem_data_in   out  BITS  registered write data to the buffer
//  mem_ready     in   1     buffer ready
//  mem_overflow  in   1     buffer overflow flag
//  count         out  ADDR_WIDTH+1  words held, range 0..WORD_DEPTH
//  err           out  1     sticky; set on mem_overflow
// BEHAVIOUR
//  Reset (rst_n=0 at an edge) values:
//   - state=INIT; count=0; err=0; last=1, so req0 wins the first tie.
//   - mem_write=0, mem_read=0, mem_data_in=0.
//   - All grants 0 while rst_n=0. Reset mid-transfer drops the transfer; counter returns to 0.
//  FSM:
//   - INIT -> RUN when mem_ready=1.
//   - RUN -> HALT when mem_overflow=1.
//   - HALT -> INIT on clr_err=1.
//   - No grants are issued in INIT or HALT.
//  Write arbitration (RUN only):
//   - wr_ok = (count < WORD_DEPTH).
//   - Single requester: it is granted.
//   - Both requesting: the one not equal to last is granted; last updates on each accepted write.
//   - At most one gnt high per cycle. No grant when wr_ok=0; there is no full-bypass on a same-cycle read.
//  Read (RUN only):
//   - rd_gnt = rd_req & (count != 0).
//  Latency: an accepted write at edge N gives mem_write=1 and mem_data_in=winner data during cycle N+1.
//   An accepted read gives mem_read=1 during cycle N+1. Strobes are one-cycle pulses; mem_data_in holds its last value otherwise.
//  count update per edge:
//   - +1 on write only, -1 on read only.
//   - Unchanged when a write and a read are both accepted or neither is.
//   - Never exceeds WORD_DEPTH and never goes below 0.
//  err is set at the edge mem_overflow=1 is sampled, in any state. It stays set until clr_err in HALT; clr_err in other states is ignored.
// TESTING
//  1. Reset, mem_ready=1, req0 alone with data 0x0E0..0x0E7 -> 8 grants; mem_write one cycle after each grant; count=8; gnt0=0 on the 9th request.
//  2. req0 and req1 held together from empty -> grants alternate 0,1,0,1; mem_data_in alternates data0 and data1; count climbs to 8 and grants stop.
//  3. count=5, req0 and rd_req both granted for 3 cycles -> count stays 5; mem_write and mem_read both high for 3 cycles.
//  4. count=0, rd_req=1 -> rd_gnt=0 and mem_read=0; count=8 with both req and rd_req -> only the read is granted, count=7.
//  5. Pulse mem_overflow in RUN -> err=1, state HALT, no grants; clr_err -> INIT; then mem_ready -> RUN; count is preserved.
//  6. rst_n=0 while count=6 and grants are active -> next cycle count=0, all strobes 0, state INIT.

Source files
------------

// File: rtl/sram_wr_arbiter.sv
// Round-robin write arbiter and access sequencer for the 8-word SRAM FIFO buffer.
// Two producers share the buffer's write port; one consumer's reads pass through.
module sram_wr_arbiter #(
  parameter int unsigned BITS       = 12,
  parameter int unsigned WORD_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [BITS-1:0]       data0,
  input  logic [BITS-1:0]       data1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  input  logic                  clr_err,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [BITS-1:0]       mem_data_in,
  input  logic                  mem_ready,
  input  logic                  mem_overflow,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err
);

  typedef enum logic [1:0] {StInit, StRun, StHalt} state_e;

  localparam logic [ADDR_WIDTH:0] DepthW = WORD_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic [BITS-1:0]     mem_data_in_q, mem_data_in_d;

  logic run, wr_ok, wr_acc;

  // Grants are forced low while reset is asserted, independent of the state register.
  assign run    = rst_n && (state_q == StRun);
  assign wr_ok  = count_q < DepthW;
  assign gnt0   = run && wr_ok && req0 && (!req1 || last_q);
  assign gnt1   = run && wr_ok && req1 && (!req0 || !last_q);
  assign rd_gnt = run && rd_req && (count_q != '0);
  assign wr_acc = gnt0 || gnt1;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    last_d        = last_q;
    err_d         = err_q;
    mem_write_d   = wr_acc;
    mem_read_d    = rd_gnt;
    mem_data_in_d = mem_data_in_q;

    unique case (state_q)
      StInit:  if (mem_ready)    state_d = StRun;
      StRun:   if (mem_overflow) state_d = StHalt;
      StHalt:  if (clr_err)      state_d = StInit;
      default: state_d = StInit;
    endcase

    if (wr_acc && !rd_gnt) begin
      count_d = count_q + CntOne;
    end else if (rd_gnt && !wr_acc) begin
      count_d = count_q - CntOne;
    end

    if (gnt1) begin
      last_d        = 1'b1;
      mem_data_in_d = data1;
    end else if (gnt0) begin
      last_d        = 1'b0;
      mem_data_in_d = data0;
    end

    // A fresh overflow wins over a simultaneous clear.
    if (mem_overflow) begin
      err_d = 1'b1;
    end else if (clr_err && (state_q == StHalt)) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StInit;
      count_q       <= '0;
      last_q        <= 1'b1;
      err_q         <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      last_q        <= last_d;
      err_q         <= err_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign count       = count_q;
  assign err         = err_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Directed bench for sram_wr_arbiter: expected write data / reads go into queues,
// a negedge monitor checks the buffer strobes against them.
module tb_sram_wr_arbiter;

  localparam int unsigned BITS = 12;
  localparam int unsigned AW   = 3;

  logic            clk = 1'b0;
  logic            rst_n, req0, req1, rd_req, clr_err, mem_ready, mem_overflow;
  logic [BITS-1:0] data0, data1;
  logic            gnt0, gnt1, rd_gnt, mem_write, mem_read, err;
  logic [BITS-1:0] mem_data_in;
  logic [AW:0]     count;

  int n_vec  = 0;
  int n_miss = 0;

  logic [BITS-1:0] exp_wr[$];
  int              exp_rd[$];

  always #5 clk = ~clk;

  sram_wr_arbiter #(.BITS(BITS), .WORD_DEPTH(8), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .rd_req(rd_req), .rd_gnt(rd_gnt), .clr_err(clr_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data_in(mem_data_in),
    .mem_ready(mem_ready), .mem_overflow(mem_overflow), .count(count), .err(err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: registered strobes are stable at the falling edge.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected mem_write", 1, 0);
      end else begin
        chk("mem_data_in", int'(mem_data_in), int'(exp_wr.pop_front()));
      end
    end
    if (mem_read === 1'b1) begin
      if (exp_rd.size() == 0) chk("unexpected mem_read", 1, 0);
      else chk("mem_read", 1, exp_rd.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; rd_req = 0; clr_err = 0; mem_overflow = 0;
    data0 = '0; data1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0; mem_ready = 0;
    step(); step();
    rst_n = 1; mem_ready = 1;
    step();
  endtask

  task automatic read_n(input int n);
    rd_req = 1;
    for (int i = 0; i < n; i++) begin
      #1 chk("rd_gnt drain", int'(rd_gnt), 1);
      exp_rd.push_back(1);
      step();
    end
    rd_req = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0; mem_ready = 0;
    req0 = 1;
    step();
    #1 chk("gnt0 in reset", int'(gnt0), 0);
    step();
    chk("reset count", int'(count), 0);
    chk("reset err", int'(err), 0);
    chk("reset mem_write", int'(mem_write), 0);
    chk("reset mem_data_in", int'(mem_data_in), 0);
    req0 = 0;
    rst_n = 1; mem_ready = 1;
    step();

    // 1: single producer fills the buffer
    req0 = 1;
    for (int i = 0; i < 8; i++) begin
      data0 = 12'h0E0 + BITS'(i);
      #1 chk("t1 gnt0", int'(gnt0), 1);
      exp_wr.push_back(12'h0E0 + BITS'(i));
      step();
    end
    chk("t1 count full", int'(count), 8);
    #1 chk("t1 gnt0 when full", int'(gnt0), 0);
    req0 = 0;
    read_n(8);
    chk("t1 count drained", int'(count), 0);

    // 4a: read on empty buffer
    rd_req = 1;
    #1 chk("t4 rd_gnt empty", int'(rd_gnt), 0);
    step();
    chk("t4 mem_read empty", int'(mem_read), 0);
    rd_req = 0;

    // 2: both producers, alternating from a fresh reset
    do_reset();
    req0 = 1; req1 = 1; data0 = 12'hA00; data1 = 12'hB00;
    for (int i = 0; i < 8; i++) begin
      data0 = 12'hA00 + BITS'(i);
      data1 = 12'hB00 + BITS'(i);
      #1;
      chk("t2 gnt0", int'(gnt0), (i % 2 == 0) ? 1 : 0);
      chk("t2 gnt1", int'(gnt1), (i % 2 == 1) ? 1 : 0);
      exp_wr.push_back((i % 2 == 0) ? 12'hA00 + BITS'(i) : 12'hB00 + BITS'(i));
      step();
    end
    chk("t2 count", int'(count), 8);
    #1 chk("t2 no grant full", int'(gnt0 | gnt1), 0);
    req1 = 0;

    // 4b: full buffer, write and read together -> only the read
    rd_req = 1;
    #1 chk("t4 gnt0 full", int'(gnt0), 0);
    chk("t4 rd_gnt full", int'(rd_gnt), 1);
    exp_rd.push_back(1);
    step();
    chk("t4 count 7", int'(count), 7);
    req0 = 0;
    rd_req = 0;
    read_n(2);

    // 3: simultaneous write and read keep the count
    chk("t3 count 5", int'(count), 5);
    req0 = 1; rd_req = 1;
    for (int i = 0; i < 3; i++) begin
      data0 = 12'h300 + BITS'(i);
      #1 chk("t3 gnt0", int'(gnt0), 1);
      chk("t3 rd_gnt", int'(rd_gnt), 1);
      exp_wr.push_back(12'h300 + BITS'(i));
      exp_rd.push_back(1);
      step();
    end
    req0 = 0; rd_req = 0;
    chk("t3 count held", int'(count), 5);

    // 5: overflow halts, clr_err returns to INIT, count preserved
    mem_overflow = 1;
    step();
    mem_overflow = 0;
    chk("t5 err set", int'(err), 1);
    req0 = 1; rd_req = 1;
    #1 chk("t5 halt gnt0", int'(gnt0), 0);
    chk("t5 halt rd_gnt", int'(rd_gnt), 0);
    step();
    chk("t5 err sticky", int'(err), 1);
    req0 = 0; rd_req = 0;
    mem_ready = 0; clr_err = 1;
    step();
    clr_err = 0;
    chk("t5 err cleared", int'(err), 0);
    req0 = 1;
    #1 chk("t5 init gnt0", int'(gnt0), 0);
    step();
    chk("t5 count preserved", int'(count), 5);
    mem_ready = 1;
    step();
    data0 = 12'h555;
    #1 chk("t5 run gnt0", int'(gnt0), 1);
    exp_wr.push_back(12'h555);
    step();
    chk("t5 count 6", int'(count), 6);

    // 6: reset while grants are active
    rd_req = 1;
    #1 chk("t6 gnt0 active", int'(gnt0), 1);
    rst_n = 0;
    #1 chk("t6 gnt0 in reset", int'(gnt0), 0);
    chk("t6 rd_gnt in reset", int'(rd_gnt), 0);
    step();
    chk("t6 count", int'(count), 0);
    chk("t6 mem_write", int'(mem_write), 0);
    chk("t6 mem_read", int'(mem_read), 0);
    rst_n = 1; mem_ready = 0;
    #1 chk("t6 init gnt0", int'(gnt0), 0);
    idle_inputs();
    step(); step();

    chk("write queue empty", exp_wr.size(), 0);
    chk("read queue empty", exp_rd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
